// File: rtl/apb_initiator.sv
// rtl/apb_initiator.sv - APB master turning single host requests into APB transfers to the USRT block
//
// One transfer at a time: SETUP (1 cycle), ACCESS (held until i_Pready), then a
// one-cycle response pulse in the first IDLE cycle. All outputs are registered.
// Slave register map: Paddr[31:30] 00 = status, 01 = transmit, 10 = receive.
//
// Optional feature macro: APB_INITIATOR_TIMEOUT_EN
//   defined   : ACCESS aborts after TIMEOUT_CYCLES cycles without i_Pready,
//               responding with o_Rsp_Err=1.
//   undefined : ACCESS waits indefinitely; o_Rsp_Err is tied to 0.
//
// Ports:
//   i_Clk, i_Rst                      clock, asynchronous active-high reset
//   i_Req_Valid / o_Req_Ready         host request handshake
//   i_Req_Write, i_Req_Addr, i_Req_Wdata  request direction, address, write data
//   o_Rsp_Valid, o_Rsp_Rdata, o_Rsp_Err   response pulse, read data, abort flag
//   o_Paddr, o_Psel, o_Penable, o_Pwrite, o_Pwdata  APB request side
//   i_Prdata, i_Pready                APB completion side

module apb_initiator #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Req_Valid,
    output logic              o_Req_Ready,
    input  logic              i_Req_Write,
    input  logic [31:0]       i_Req_Addr,
    input  logic [DATA_W-1:0] i_Req_Wdata,
    output logic              o_Rsp_Valid,
    output logic [DATA_W-1:0] o_Rsp_Rdata,
    output logic              o_Rsp_Err,
    output logic [31:0]       o_Paddr,
    output logic              o_Psel,
    output logic              o_Penable,
    output logic              o_Pwrite,
    output logic [DATA_W-1:0] o_Pwdata,
    input  logic [DATA_W-1:0] i_Prdata,
    input  logic              i_Pready
);

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("apb_initiator: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETUP  = 2'b01,
        S_ACCESS = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic              req_ready_nxt;
    logic              psel_nxt;
    logic              penable_nxt;
    logic              pwrite_nxt;
    logic              rsp_valid_nxt;
    logic [31:0]       paddr_nxt;
    logic [DATA_W-1:0] pwdata_nxt;
    logic [DATA_W-1:0] rdata_nxt;

`ifdef APB_INITIATOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             rsp_err_nxt;
    logic             timeout_hit;

    // wait_cnt holds the number of already-elapsed ACCESS cycles without
    // i_Pready, so the last allowed cycle is the one where it equals TIMEOUT-1.
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_nxt     = state;
        req_ready_nxt = o_Req_Ready;
        psel_nxt      = o_Psel;
        penable_nxt   = o_Penable;
        pwrite_nxt    = o_Pwrite;
        paddr_nxt     = o_Paddr;
        pwdata_nxt    = o_Pwdata;
        rdata_nxt     = o_Rsp_Rdata;
        rsp_valid_nxt = 1'b0;
`ifdef APB_INITIATOR_TIMEOUT_EN
        wait_cnt_nxt  = wait_cnt;
        rsp_err_nxt   = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                req_ready_nxt = 1'b1;
                psel_nxt      = 1'b0;
                penable_nxt   = 1'b0;
                if (i_Req_Valid && o_Req_Ready) begin
                    state_nxt     = S_SETUP;
                    req_ready_nxt = 1'b0;
                    psel_nxt      = 1'b1;
                    paddr_nxt     = i_Req_Addr;
                    pwrite_nxt    = i_Req_Write;
                    pwdata_nxt    = i_Req_Wdata;
`ifdef APB_INITIATOR_TIMEOUT_EN
                    wait_cnt_nxt  = '0;
`endif
                end
            end

            S_SETUP: begin
                state_nxt     = S_ACCESS;
                req_ready_nxt = 1'b0;
                psel_nxt      = 1'b1;
                penable_nxt   = 1'b1;
            end

            S_ACCESS: begin
                // i_Pready wins over the timeout so a ready in the final
                // counted cycle still completes cleanly.
                if (i_Pready) begin
                    state_nxt     = S_IDLE;
                    req_ready_nxt = 1'b1;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    if (!o_Pwrite) begin
                        rdata_nxt = i_Prdata;
                    end
                end
`ifdef APB_INITIATOR_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_nxt     = S_IDLE;
                    req_ready_nxt = 1'b1;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
`endif
            end

            default: begin
                state_nxt     = S_IDLE;
                req_ready_nxt = 1'b1;
                psel_nxt      = 1'b0;
                penable_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= S_IDLE;
            o_Req_Ready <= 1'b1;
            o_Psel      <= 1'b0;
            o_Penable   <= 1'b0;
            o_Pwrite    <= 1'b0;
            o_Paddr     <= '0;
            o_Pwdata    <= '0;
            o_Rsp_Rdata <= '0;
            o_Rsp_Valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_Req_Ready <= req_ready_nxt;
            o_Psel      <= psel_nxt;
            o_Penable   <= penable_nxt;
            o_Pwrite    <= pwrite_nxt;
            o_Paddr     <= paddr_nxt;
            o_Pwdata    <= pwdata_nxt;
            o_Rsp_Rdata <= rdata_nxt;
            o_Rsp_Valid <= rsp_valid_nxt;
        end
    end

`ifdef APB_INITIATOR_TIMEOUT_EN
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wait_cnt  <= '0;
            o_Rsp_Err <= 1'b0;
        end else begin
            wait_cnt  <= wait_cnt_nxt;
            o_Rsp_Err <= rsp_err_nxt;
        end
    end
`else
    assign o_Rsp_Err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_initiator.sv
// tb/tb_apb_initiator.sv - self-checking bench for apb_initiator

module tb_apb_initiator;

    localparam int DATA_W = 32;
    localparam int TO     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] prdata    = '0;
    logic        pready    = 1'b1;

    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    apb_initiator #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Req_Valid (req_valid),
        .o_Req_Ready (req_ready),
        .i_Req_Write (req_write),
        .i_Req_Addr  (req_addr),
        .i_Req_Wdata (req_wdata),
        .o_Rsp_Valid (rsp_valid),
        .o_Rsp_Rdata (rsp_rdata),
        .o_Rsp_Err   (rsp_err),
        .o_Paddr     (paddr),
        .o_Psel      (psel),
        .o_Penable   (penable),
        .o_Pwrite    (pwrite),
        .o_Pwdata    (pwdata),
        .i_Prdata    (prdata),
        .i_Pready    (pready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            passes++;
    endtask

    // Transfer-level model: a transfer is either absent, in its setup cycle,
    // or waiting for ready; the response is flagged for the cycle after it ends.
    bit          m_busy  = 1'b0;
    bit          m_setup = 1'b0;
    bit          m_rsp   = 1'b0;
    bit          m_err   = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    logic        m_write = 1'b0;
`ifdef APB_INITIATOR_TIMEOUT_EN
    int          m_idle_waits = 0;
`endif

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 0; m_setup = 0; m_rsp = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_write = 1'b0;
        end else begin
            m_rsp = 0;
            m_err = 0;
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy  = 1; m_setup = 1;
                    m_addr  = req_addr; m_write = req_write; m_wdata = req_wdata;
`ifdef APB_INITIATOR_TIMEOUT_EN
                    m_idle_waits = 0;
`endif
                end
            end else if (m_setup) begin
                m_setup = 0;
            end else if (pready) begin
                m_busy = 0;
                m_rsp  = 1;
                if (!m_write) m_rdata = prdata;
            end else begin
`ifdef APB_INITIATOR_TIMEOUT_EN
                m_idle_waits++;
                if (m_idle_waits == TO) begin
                    m_busy = 0; m_rsp = 1; m_err = 1;
                end
`endif
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("cmp_req_ready", req_ready, !m_busy);
        check("cmp_psel",      psel,      m_busy);
        check("cmp_penable",   penable,   m_busy && !m_setup);
        check("cmp_rsp_valid", rsp_valid, m_rsp);
        check("cmp_rsp_err",   rsp_err,   m_err);
        check("cmp_rsp_rdata", rsp_rdata, m_rdata);
        check("cmp_paddr",     paddr,     m_addr);
        check("cmp_pwrite",    pwrite,    m_write);
        check("cmp_pwdata",    pwdata,    m_wdata);
    end

    initial begin
        int          pen_cnt;
        int          rsp_at;
        logic [31:0] got_rdata;
        logic [5:0]  psel_hist;
        bit          seen_rsp;
        bit          seen_psel;

        repeat (2) @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_psel",      psel,      0);
        check("reset_penable",   penable,   0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_paddr",     paddr,     0);
        check("reset_rdata",     rsp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // write, zero wait states
        req_write = 1; req_addr = 32'h4000_0000; req_wdata = 32'h41; pready = 1; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        check("wr_setup_psel",    psel,      1);
        check("wr_setup_penable", penable,   0);
        check("wr_setup_paddr",   paddr,     32'h4000_0000);
        check("wr_setup_pwdata",  pwdata,    32'h41);
        check("wr_setup_pwrite",  pwrite,    1);
        check("wr_setup_ready",   req_ready, 0);
        @(negedge clk);
        check("wr_access_penable", penable, 1);
        @(negedge clk);
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err",   rsp_err,   0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_rsp_psel",  psel,      0);
        @(negedge clk);
        check("wr_rsp_once", rsp_valid, 0);

        // read, two wait states; i_Prdata is garbage while not ready
        req_write = 0; req_addr = 32'h8000_0000; pready = 0; prdata = 32'hDEAD_BEEF; req_valid = 1;
        pen_cnt = 0; rsp_at = -1; got_rdata = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 0;
            if (penable) pen_cnt++;
            if (rsp_valid && rsp_at < 0) begin
                rsp_at    = n;
                got_rdata = rsp_rdata;
            end
            pready = penable && (pen_cnt >= 3);
            prdata = pready ? 32'h5A : 32'hDEAD_BEEF;
        end
        check("rd_penable_cycles", pen_cnt,   3);
        check("rd_rsp_latency",    rsp_at,    5);
        check("rd_rsp_rdata",      got_rdata, 32'h5A);
        pready = 1;

        // back-to-back with i_Req_Valid held: status read then transmit write
        req_write = 0; req_addr = 32'h0000_0000; prdata = 32'h33; req_valid = 1;
        psel_hist = '0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            psel_hist[n-1] = psel;
            if (n == 1) begin
                req_write = 1; req_addr = 32'h4000_0000; req_wdata = 32'h42;
            end
            if (n == 3) begin
                check("b2b_rsp1_valid", rsp_valid, 1);
                check("b2b_rsp1_ready", req_ready, 1);
                check("b2b_rsp1_rdata", rsp_rdata, 32'h33);
            end
            if (n == 4) begin
                req_valid = 0;
                check("b2b_setup2_paddr",  paddr,  32'h4000_0000);
                check("b2b_setup2_pwrite", pwrite, 1);
                check("b2b_setup2_pwdata", pwdata, 32'h42);
            end
            if (n == 6) begin
                check("b2b_rsp2_valid", rsp_valid, 1);
                check("b2b_rsp2_rdata", rsp_rdata, 32'h33);
            end
        end
        check("b2b_psel_pattern", psel_hist, 6'b011011);

        // busy rejection: inputs wiggle while the transfer is in flight
        req_write = 1; req_addr = 32'h4000_0004; req_wdata = 32'h99; pready = 0; req_valid = 1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            check("busy_ready", req_ready, 0);
            check("busy_paddr", paddr,     32'h4000_0004);
            req_valid = n[0];
            req_addr  = $urandom;
        end
        req_valid = 0; pready = 1;
        @(negedge clk);
        check("busy_rsp_valid", rsp_valid, 1);
        check("busy_rsp_paddr", paddr,     32'h4000_0004);
        @(negedge clk);
        check("busy_no_extra", psel, 0);

        // reset in the middle of ACCESS
        req_write = 0; req_addr = 32'h8000_0000; pready = 0; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        check("rst_pre_penable", penable, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_psel",      psel,      0);
        check("rst_penable",   penable,   0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ready",     req_ready, 1);
        @(negedge clk);
        rst = 1'b0; pready = 1;
        seen_rsp = 0; seen_psel = 0;
        repeat (6) begin
            @(negedge clk);
            seen_rsp  |= rsp_valid;
            seen_psel |= psel;
        end
        check("rst_no_rsp",  seen_rsp,  0);
        check("rst_no_psel", seen_psel, 0);
        check("rst_ready_after", req_ready, 1);

`ifdef APB_INITIATOR_TIMEOUT_EN
        // timeout: four ACCESS cycles without ready
        req_write = 0; req_addr = 32'h8000_0000; prdata = 32'h77; pready = 0; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        for (int n = 2; n <= 5; n++) begin
            @(negedge clk);
            check("to_access_penable", penable, 1);
        end
        @(negedge clk);
        check("to_psel",      psel,      0);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err",   rsp_err,   1);
        check("to_rsp_rdata", rsp_rdata, 0);
        @(negedge clk);
        // ready arriving in the final counted cycle completes normally
        req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        for (int n = 2; n <= 5; n++) begin
            @(negedge clk);
            if (n == 5) pready = 1;
        end
        @(negedge clk);
        check("to_edge_rsp_valid", rsp_valid, 1);
        check("to_edge_rsp_err",   rsp_err,   0);
        check("to_edge_rsp_rdata", rsp_rdata, 32'h77);
`else
        // no timeout: ACCESS holds for as long as ready stays low
        req_write = 1; req_addr = 32'h4000_0008; req_wdata = 32'h55; pready = 0; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        pen_cnt = 0;
        repeat (110) begin
            @(negedge clk);
            if (penable) pen_cnt++;
        end
        check("nto_penable_cycles", pen_cnt, 110);
        pready = 1;
        @(negedge clk);
        check("nto_rsp_valid", rsp_valid, 1);
        check("nto_rsp_err",   rsp_err,   0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/apb_initiator.md
Name: apb_initiator

Overview:
- APB master that turns single-word host requests into APB transfers toward the USRT register block.
- Register map on the slave side: status at Paddr[31:30]=00, transmit at 01, receive at 10.
- Sits between the host-side controller and the USRT peripheral bus.
- Issues one transfer at a time: SETUP phase, then ACCESS phase with Pready wait states, then a one-cycle response pulse to the host.

Parameters:
- DATA_W, 32: width of Pwdata, Prdata and the request/response data.
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles without Pready before the transfer is aborted. Used only with APB_INITIATOR_TIMEOUT_EN.

Ports:
- i_Clk  in  1  system clock; all logic is on the rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Req_Valid  in  1  host request valid.
- o_Req_Ready  out  1  initiator can accept a request.
- i_Req_Write  in  1  1 = write, 0 = read.
- i_Req_Addr  in  32  target address.
- i_Req_Wdata  in  DATA_W  write data.
- o_Rsp_Valid  out  1  one-cycle pulse when a transfer completes.
- o_Rsp_Rdata  out  DATA_W  read data; updated only by successful reads.
- o_Rsp_Err  out  1  qualifies o_Rsp_Valid; 1 = transfer aborted.
- o_Paddr  out  32  APB address.
- o_Psel  out  1  APB select.
- o_Penable  out  1  APB enable.
- o_Pwrite  out  1  APB direction.
- o_Pwdata  out  DATA_W  APB write data.
- i_Prdata  in  DATA_W  APB read data.
- i_Pready  in  1  APB ready (wait-state insertion).

Behaviour:
- All outputs are registered. Reset values:
  - o_Req_Ready=1
  - every other output 0
  - state IDLE
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - o_Req_Ready=1, o_Psel=0, o_Penable=0.
  - A request is accepted when i_Req_Valid & o_Req_Ready at a clock edge.
  - On acceptance, latch i_Req_Addr, i_Req_Write and i_Req_Wdata into o_Paddr, o_Pwrite and o_Pwdata, and go to SETUP.
- SETUP: exactly 1 cycle. o_Psel=1, o_Penable=0, o_Req_Ready=0. Next state is ACCESS unconditionally.
- ACCESS:
  - o_Psel=1, o_Penable=1, o_Req_Ready=0.
  - If i_Pready=0, stay in ACCESS.
  - If i_Pready=1 at the clock edge, go to IDLE. If it was a read, capture i_Prdata into o_Rsp_Rdata.
- Response: o_Rsp_Valid=1 for exactly the first IDLE cycle after the transfer, with o_Rsp_Err=0. o_Rsp_Valid is 0 in every other cycle.
- Back-to-back: a request may be accepted in the same cycle as the response pulse.
  - Minimum transfer period is 3 cycles: SETUP, ACCESS, IDLE.
  - Accept to response is 2 + wait-state cycles.
- Stability:
  - o_Paddr, o_Pwrite and o_Pwdata are constant from SETUP through the last ACCESS cycle.
  - After the transfer they hold their last value until the next acceptance.
  - Request inputs are ignored when o_Req_Ready=0; no queuing or buffering.
- Write responses leave o_Rsp_Rdata unchanged.
- Reset mid-transfer: return immediately to IDLE with reset values. The in-flight transfer is dropped and no response is produced.
- Any state encoding not listed above recovers to IDLE.

Optional Feature:
- Macro: APB_INITIATOR_TIMEOUT_EN.
- Defined:
  - An ACCESS-cycle counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to SETUP and increments each ACCESS cycle while i_Pready=0.
  - When TIMEOUT_CYCLES consecutive ACCESS cycles pass without i_Pready, go to IDLE with o_Psel=0 and o_Penable=0.
  - Pulse o_Rsp_Valid=1 with o_Rsp_Err=1; o_Rsp_Rdata is unchanged.
  - If i_Pready=1 arrives in the final counted cycle, it completes normally with no error.
- Undefined: no counter; ACCESS waits indefinitely for i_Pready; o_Rsp_Err is tied to 0.

Test Plan:
- Write with zero wait states: request accepted at edge N with addr=0x4000_0000, wdata=0x0000_0041, i_Pready=1.
  - Cycle N+1: o_Psel=1, o_Penable=0, o_Paddr=0x4000_0000, o_Pwdata=0x41, o_Pwrite=1.
  - Cycle N+2: o_Penable=1.
  - Cycle N+3: o_Rsp_Valid=1, o_Rsp_Err=0, o_Rsp_Rdata unchanged.
- Read with 2 wait states: addr=0x8000_0000, i_Pready low for 2 ACCESS cycles then high, i_Prdata=0x5A.
  - o_Penable high for 3 cycles.
  - Response 5 cycles after accept with o_Rsp_Rdata=0x5A.
- Back-to-back: i_Req_Valid held high with status read 0x0000_0000 then write 0x4000_0000.
  - Second accept occurs in the response cycle of the first.
  - o_Psel drops for exactly 1 cycle between the two transfers.
- Busy rejection: toggle i_Req_Addr and i_Req_Valid during SETUP and ACCESS → o_Req_Ready=0 and o_Paddr stays stable.
- Reset mid-ACCESS: assert i_Rst while o_Penable=1 → o_Psel, o_Penable and o_Rsp_Valid go to 0 immediately; after release, o_Req_Ready=1 and no response pulse appears.
- Timeout (macro defined, TIMEOUT_CYCLES=4): i_Pready held 0.
  - After 4 ACCESS cycles, o_Psel=0.
  - Next cycle has o_Rsp_Valid=1, o_Rsp_Err=1.
  - Without the macro, o_Penable stays high for 100+ cycles.
